// File: rtl/ddr2_host_pkg.sv
// Shared definitions for the dram_controller host-port master: state encoding
// and default bus widths matching the controller's address/data ports.
package ddr2_host_pkg;

  localparam int ADDR_W_DEF = 23;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    WAIT_INIT,
    IDLE,
    SETUP,
    WAIT_BUSY,
    WAIT_DONE,
    RELEASE
  } state_t;

endpackage

// File: rtl/ddr2_host_port_master.sv
// Turns a valid/ready byte request stream into the CEb/WEb/ready handshake of
// dram_controller's SRAM-style port, with setup/recovery spacing and timeouts.
module ddr2_host_port_master
  import ddr2_host_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int SETUP_CYC    = 1,
  parameter int RECOVERY_CYC = 2,
  parameter int TIMEOUT_CYC  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_done,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              CEb,
  output logic              WEb,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dout,
  output logic              dout_oe,
  input  logic [DATA_W-1:0] din,
  input  logic              ready
);

  // Wide enough for the timeout budget and for the 4-bit setup/recovery loads.
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 4) ? $clog2(TIMEOUT_CYC + 1) : 4;

  localparam logic [CNT_W-1:0] SETUP_LD    = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] RECOVERY_LD = CNT_W'(RECOVERY_CYC);
  localparam logic [CNT_W-1:0] TIMEOUT_LD  = CNT_W'(TIMEOUT_CYC);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_tick;
  logic             done_hit;
  logic             timeout_hit;

  // Phases are loaded with N and end on the edge where the count reads 1,
  // so each phase lasts exactly N cycles.
  assign last_tick   = (cnt == CNT_W'(1));
  assign done_hit    = (state == WAIT_DONE) && ready;
  assign timeout_hit = last_tick &&
                       (((state == WAIT_BUSY) && ready) ||
                        ((state == WAIT_DONE) && !ready));

  assign req_ready = (state == IDLE) && init_done && ready;

  // NOTE: every register here is state, so all updates use non-blocking
  // assignments; later assignments in the same edge override earlier defaults.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= WAIT_INIT;
      cnt       <= '0;
      CEb       <= 1'b1;
      WEb       <= 1'b1;
      addr      <= '0;
      dout      <= '0;
      dout_oe   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      if (cnt != '0) cnt <= cnt - 1'b1;

      case (state)
        WAIT_INIT: if (init_done) state <= IDLE;
        IDLE: begin
          if (!init_done) begin
            state <= WAIT_INIT;
          end else if (req_valid && ready) begin
            addr <= req_addr;
            WEb  <= ~req_we;
            if (req_we) begin
              dout    <= req_wdata;
              dout_oe <= 1'b1;
            end
            cnt   <= SETUP_LD;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (last_tick) begin
            CEb   <= 1'b0;
            cnt   <= TIMEOUT_LD;
            state <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (!ready) begin
            cnt   <= TIMEOUT_LD;
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: ;
        RELEASE:   if (last_tick) state <= IDLE;
        default:   state <= WAIT_INIT;
      endcase

      // Normal completion and timeout abort share the bus release sequence.
      if (done_hit || timeout_hit) begin
        rsp_valid <= 1'b1;
        rsp_err   <= timeout_hit;
        rsp_rdata <= (done_hit && WEb) ? din : '0;
        CEb       <= 1'b1;
        WEb       <= 1'b1;
        dout_oe   <= 1'b0;
        cnt       <= RECOVERY_LD;
        state     <= RELEASE;
      end
    end
  end

endmodule

// File: tb/tb_ddr2_host_port_master.sv
// Bench for ddr2_host_port_master against a behavioural dram_controller port
// stub, with an address->byte reference memory predicting read data.
module tb_ddr2_host_port_master;

  localparam int AW    = 23;
  localparam int DW    = 8;
  localparam int SETUP = 3;
  localparam int RECOV = 4;
  localparam int TMO   = 1024;

  logic          clk = 1'b0;
  logic          reset;
  logic          init_done;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          CEb;
  logic          WEb;
  logic [AW-1:0] addr;
  logic [DW-1:0] dout;
  logic          dout_oe;
  logic [DW-1:0] din = '0;
  logic          ready = 1'b1;

  ddr2_host_port_master #(
    .ADDR_W(AW), .DATA_W(DW), .SETUP_CYC(SETUP), .RECOVERY_CYC(RECOV), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .reset(reset), .init_done(init_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .CEb(CEb), .WEb(WEb), .addr(addr), .dout(dout), .dout_oe(dout_oe),
    .din(din), .ready(ready)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_rise   = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Controller stub: after seeing CEb low it goes busy for a few cycles, then
  // commits the write or returns the stored byte while raising ready again.
  logic [DW-1:0] ctl_mem [int];
  int stub_st   = 0;
  int busy_left = 0;
  bit stuck_high = 0;  // never goes busy
  bit stuck_low  = 0;  // goes busy and never finishes

  always @(posedge clk) begin
    if (reset) begin
      stub_st <= 0;
      ready   <= 1'b1;
    end else begin
      case (stub_st)
        0: if (!CEb && !stuck_high) begin
          ready     <= 1'b0;
          busy_left <= int'($urandom_range(1, 5));
          stub_st   <= 1;
        end
        1: if (!stuck_low) begin
          if (busy_left <= 1) begin
            ready   <= 1'b1;
            stub_st <= 2;
            if (!WEb) ctl_mem[int'(addr)] = dout_oe ? dout : 'x;
            else din <= ctl_mem.exists(int'(addr)) ? ctl_mem[int'(addr)] : '0;
          end else begin
            busy_left <= busy_left - 1;
          end
        end
        default: if (CEb) stub_st <= 0;
      endcase
    end
  end

  // Reference model: the last byte successfully written to each address.
  logic [DW-1:0] ref_mem [int];

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
  endfunction

  // Called at a negedge; presents one request and follows it to its response.
  task automatic do_req(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit expect_err);
    int waits, acc_cyc, fall_cyc, rsp_cyc;
    bit idle_ok, hold_ok;
    logic [DW-1:0] exp_data;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    waits = 0; idle_ok = 1;
    while (!req_ready && waits < 2000) begin
      if (!CEb || dout_oe) idle_ok = 0;
      @(negedge clk); waits++;
    end
    check("accept_seen", req_ready, 1'b1);
    check("idle_bus_quiet", idle_ok, 1'b1);
    if (!req_ready) begin req_valid = 1'b0; return; end
    @(negedge clk);
    acc_cyc = cyc;
    // Scramble request inputs: they must be ignored after the accept cycle.
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = AW'($urandom); req_wdata = DW'($urandom);
    fall_cyc = -1; hold_ok = 1; waits = 0;
    while (!rsp_valid && waits < 3000) begin
      if (!CEb && fall_cyc < 0) fall_cyc = cyc;
      if (addr !== a || WEb !== ~we || dout_oe !== we || (we && dout !== d)) hold_ok = 0;
      @(negedge clk); waits++;
    end
    rsp_cyc = cyc;
    check("rsp_seen", rsp_valid, 1'b1);
    check("setup_delay", fall_cyc - acc_cyc, SETUP);
    check("bus_hold", hold_ok, 1'b1);
    if (last_rise >= 0 && fall_cyc >= 0) check("recovery_ok", (fall_cyc - last_rise) >= RECOV, 1'b1);
    if (expect_err) check("timeout_len", rsp_cyc - fall_cyc, TMO);
    exp_data = (we || expect_err) ? '0 : ref_read(a);
    check("rsp_err", rsp_err, expect_err);
    check("rsp_rdata", rsp_rdata, exp_data);
    check("rsp_ceb_high", CEb, 1'b1);
    check("rsp_web_high", WEb, 1'b1);
    check("rsp_oe_low", dout_oe, 1'b0);
    if (we && !expect_err) ref_mem[int'(a)] = d;
    last_rise = rsp_cyc;
    @(negedge clk);
    check("rsp_one_cycle", rsp_valid, 1'b0);
  endtask

  logic [AW-1:0] pool [8];

  initial begin
    int waits;
    bit gate_ok, quiet;
    reset = 1'b1; init_done = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ceb", CEb, 1'b1);
    check("rst_web", WEb, 1'b1);
    check("rst_addr", addr, '0);
    check("rst_dout", dout, '0);
    check("rst_oe", dout_oe, 1'b0);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, '0);
    check("rst_rsp_err", rsp_err, 1'b0);
    reset = 1'b0;

    // Init gating with a request pending the whole time.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 23'h012345; req_wdata = 8'h5A;
    gate_ok = 1;
    repeat (500) begin
      @(negedge clk);
      if (req_ready !== 1'b0 || CEb !== 1'b1) gate_ok = 0;
    end
    check("init_gate", gate_ok, 1'b1);
    init_done = 1'b1;
    @(negedge clk);
    check("init_ready", req_ready, 1'b1);

    // Write then read, back to back.
    do_req(1'b1, 23'h012345, 8'h5A, 1'b0);
    do_req(1'b0, 23'h012345, 8'h00, 1'b0);

    // Address and data corners.
    do_req(1'b1, 23'h000000, 8'hFF, 1'b0);
    do_req(1'b1, 23'h7FFFFF, 8'h00, 1'b0);
    do_req(1'b0, 23'h000000, 8'h00, 1'b0);
    do_req(1'b0, 23'h7FFFFF, 8'h00, 1'b0);
    do_req(1'b1, 23'h000000, 8'h00, 1'b0);
    do_req(1'b1, 23'h7FFFFF, 8'hFF, 1'b0);
    do_req(1'b0, 23'h7FFFFF, 8'h00, 1'b0);
    do_req(1'b0, 23'h000000, 8'h00, 1'b0);

    // Timeout in WAIT_BUSY, then recovery with a normal access.
    stuck_high = 1;
    do_req(1'b1, 23'h0000AA, 8'hC3, 1'b1);
    stuck_high = 0;
    do_req(1'b1, 23'h0000AA, 8'h3C, 1'b0);
    do_req(1'b0, 23'h0000AA, 8'h00, 1'b0);

    // Randomised traffic over a small address pool so reads hit prior writes.
    for (int i = 0; i < 8; i++) pool[i] = AW'($urandom);
    pool[0] = '0; pool[7] = '1;
    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] a;
      a = pool[$urandom_range(0, 7)];
      do_req(1'($urandom), a, DW'($urandom), 1'b0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
    end

    // Reset while the controller holds the access in WAIT_DONE.
    stuck_low = 1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 23'h00ABCD; req_wdata = 8'h33;
    waits = 0;
    while (!req_ready && waits < 100) begin @(negedge clk); waits++; end
    check("mid_rst_accept", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    waits = 0;
    while (ready && waits < 50) begin @(negedge clk); waits++; end
    repeat (3) @(negedge clk);
    check("mid_rst_pre_ceb", CEb, 1'b0);
    check("mid_rst_pre_oe", dout_oe, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_ceb", CEb, 1'b1);
    check("mid_rst_oe", dout_oe, 1'b0);
    check("mid_rst_rsp", rsp_valid, 1'b0);
    check("mid_rst_wait_init", req_ready, 1'b0);
    stuck_low = 0;
    last_rise = -1;
    quiet = 1;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) quiet = 0;
    end
    check("mid_rst_no_rsp", quiet, 1'b1);
    check("mid_rst_idle", req_ready, 1'b1);
    do_req(1'b0, 23'h00ABCD, 8'h00, 1'b0);
    do_req(1'b0, 23'h012345, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
